// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared types and constants for the program memory loader
package program_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CSUM,
      DONE,
      ERROR
   } state_t;

   localparam int         LEN_W   = 16;
   localparam logic [7:0] CSUM_OK = 8'h00;

   // Number of 32-bit words that fit in a byte-addressed memory of addr_w bits
   function automatic int max_words(input int addr_w);
      return (1 << addr_w) / 4;
   endfunction

   localparam int MAX_WORDS = max_words(12);

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - packs accepted bytes little-endian into 32-bit words
module byte_word_packer
   import program_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  byte_i,
   input  logic        accept_i,
   input  logic        clear_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   logic [1:0]  lane_q, lane_d;
   logic [31:0] shreg_q, shreg_d;

   // Bytes shift in from the top so the first byte ends up in bits [7:0]
   always_comb begin
      lane_d  = lane_q;
      shreg_d = shreg_q;
      if (clear_i) begin
         lane_d  = 2'd0;
         shreg_d = 32'd0;
      end else if (accept_i) begin
         lane_d  = lane_q + 2'd1;
         shreg_d = {byte_i, shreg_q[31:8]};
      end
   end

   // Lane counter and shift register state
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lane_q  <= 2'd0;
         shreg_q <= 32'd0;
      end else begin
         lane_q  <= lane_d;
         shreg_q <= shreg_d;
      end
   end

   // The completed word is presented in the same cycle as its 4th byte
   assign word_valid_o = accept_i & ~clear_i & (lane_q == 2'd3);
   assign word_o       = {byte_i, shreg_q[31:8]};

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte stream to program memory writer with core hold
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clk_70_mhz,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              pm_wr_en,
   output logic [ADDR_W-1:0] pm_wr_addr,
   output logic [31:0]       pm_wr_data,
   output logic              core_hold,
   output logic              load_done,
   output logic              load_error
);

   // Widened by one bit so a 16-bit length can be compared without overflow
   localparam logic [LEN_W:0] MAX_W = (LEN_W+1)'(max_words(ADDR_W));

   state_t              state_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    wcnt_q;
   logic [7:0]          sum_q;
   logic                s_ready_q;
   logic                pm_wr_en_q;
   logic [ADDR_W-1:0]   pm_wr_addr_q;
   logic [31:0]         pm_wr_data_q;
   logic                core_hold_q;
   logic                load_done_q;
   logic                load_error_q;

   logic                xfer;
   logic                start_ok;
   logic [7:0]          sum_d;
   logic [LEN_W-1:0]    len_d;
   logic [31:0]         word;
   logic                word_valid;

   assign xfer     = s_valid & s_ready_q;
   assign start_ok = start & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERROR));
   assign sum_d    = sum_q + s_data;
   assign len_d    = {s_data, len_q[7:0]};

   byte_word_packer u_packer (
      .clk_i        (clk_70_mhz),
      .rst_i        (rst),
      .byte_i       (s_data),
      .accept_i     (xfer & (state_q == DATA)),
      .clear_i      (start_ok),
      .word_o       (word),
      .word_valid_o (word_valid)
   );

   // Frame FSM with counters, checksum and registered write-port/status outputs
   always_ff @(posedge clk_70_mhz or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         len_q        <= '0;
         wcnt_q       <= '0;
         sum_q        <= 8'd0;
         s_ready_q    <= 1'b0;
         pm_wr_en_q   <= 1'b0;
         pm_wr_addr_q <= '0;
         pm_wr_data_q <= 32'd0;
         core_hold_q  <= 1'b1;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
      end else begin
         pm_wr_en_q <= 1'b0;
         if (word_valid) begin
            pm_wr_en_q   <= 1'b1;
            pm_wr_addr_q <= {wcnt_q[ADDR_W-3:0], 2'b00};
            pm_wr_data_q <= word;
            wcnt_q       <= wcnt_q + 1'b1;
         end

         case (state_q)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  state_q      <= LEN_LO;
                  s_ready_q    <= 1'b1;
                  core_hold_q  <= 1'b1;
                  load_done_q  <= 1'b0;
                  load_error_q <= 1'b0;
                  sum_q        <= 8'd0;
                  wcnt_q       <= '0;
               end
            end
            LEN_LO: begin
               if (xfer) begin
                  len_q[7:0] <= s_data;
                  sum_q      <= sum_d;
                  state_q    <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (xfer) begin
                  len_q <= len_d;
                  sum_q <= sum_d;
                  if ({1'b0, len_d} > MAX_W) begin
                     state_q      <= ERROR;
                     s_ready_q    <= 1'b0;
                     load_error_q <= 1'b1;
                  end else if (len_d == '0) begin
                     state_q <= CSUM;
                  end else begin
                     state_q <= DATA;
                  end
               end
            end
            DATA: begin
               if (xfer) begin
                  sum_q <= sum_d;
                  if (word_valid && ((wcnt_q + 1'b1) == len_q)) begin
                     state_q <= CSUM;
                  end
               end
            end
            CSUM: begin
               if (xfer) begin
                  s_ready_q <= 1'b0;
                  if (sum_d == CSUM_OK) begin
                     state_q     <= DONE;
                     load_done_q <= 1'b1;
                     core_hold_q <= 1'b0;
                  end else begin
                     state_q      <= ERROR;
                     load_error_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               s_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready    = s_ready_q;
   assign pm_wr_en   = pm_wr_en_q;
   assign pm_wr_addr = pm_wr_addr_q;
   assign pm_wr_data = pm_wr_data_q;
   assign core_hold  = core_hold_q;
   assign load_done  = load_done_q;
   assign load_error = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic        pm_wr_en;
   logic [11:0] pm_wr_addr;
   logic [31:0] pm_wr_data;
   logic        core_hold;
   logic        load_done;
   logic        load_error;

   int tests = 0;
   int fails = 0;

   logic [11:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   logic [7:0] frame[11];

   program_loader #(.ADDR_W(12)) dut (
      .clk_70_mhz (clk),
      .rst        (rst),
      .start      (start),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .pm_wr_en   (pm_wr_en),
      .pm_wr_addr (pm_wr_addr),
      .pm_wr_data (pm_wr_data),
      .core_hold  (core_hold),
      .load_done  (load_done),
      .load_error (load_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every write strobe seen between edges
   always @(negedge clk) begin
      if (pm_wr_en === 1'b1) begin
         wr_addr_q.push_back(pm_wr_addr);
         wr_data_q.push_back(pm_wr_data);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      s_data  = b;
      s_valid = 1'b1;
      while (s_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (s_ready !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: byte %02h s_ready=%b required 1", b, s_ready);
      end
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   // Sends frame[0..count-1]; gap idle cycles after each byte; optional start pulse in the gap after byte start_at
   task automatic send_frame(input int count, input int gap, input int start_at);
      for (int i = 0; i < count; i++) begin
         send_byte(frame[i]);
         for (int g = 0; g < gap; g++) begin
            if (i == start_at && g == 0) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      end
   endtask

   task automatic check_status(input string name, input logic exp_done, input logic exp_err,
                               input logic exp_hold, input logic exp_ready);
      tests++;
      if ({load_done, load_error, core_hold, s_ready} !== {exp_done, exp_err, exp_hold, exp_ready}) begin
         fails++;
         $display("FAIL %s: done/err/hold/ready=%b%b%b%b required %b%b%b%b", name,
                  load_done, load_error, core_hold, s_ready, exp_done, exp_err, exp_hold, exp_ready);
      end
   endtask

   task automatic check_nominal_writes(input string name);
      tests++;
      if (wr_addr_q.size() != 2) begin
         fails++;
         $display("FAIL %s_count: writes=%0d required 2", name, wr_addr_q.size());
      end else begin
         tests++;
         if (wr_addr_q[0] !== 12'h000 || wr_data_q[0] !== 32'h00500093) begin
            fails++;
            $display("FAIL %s_w0: addr=%h data=%h required 000 00500093", name, wr_addr_q[0], wr_data_q[0]);
         end
         tests++;
         if (wr_addr_q[1] !== 12'h004 || wr_data_q[1] !== 32'h00100113) begin
            fails++;
            $display("FAIL %s_w1: addr=%h data=%h required 004 00100113", name, wr_addr_q[1], wr_data_q[1]);
         end
      end
   endtask

   task automatic load_nominal_frame();
      frame[0] = 8'h02; frame[1] = 8'h00;
      frame[2] = 8'h93; frame[3] = 8'h00; frame[4] = 8'h50; frame[5] = 8'h00;
      frame[6] = 8'h13; frame[7] = 8'h01; frame[8] = 8'h10; frame[9] = 8'h00;
      frame[10] = 8'hF7;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      tests++;
      if ({s_ready, pm_wr_en, pm_wr_addr, pm_wr_data} !== {1'b0, 1'b0, 12'h000, 32'h0}) begin
         fails++;
         $display("FAIL reset_outputs: ready=%b en=%b addr=%h data=%h required 0 0 000 00000000",
                  s_ready, pm_wr_en, pm_wr_addr, pm_wr_data);
      end
      check_status("reset_status", 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_status("idle_status", 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_nominal();
      load_nominal_frame();
      clear_log();
      pulse_start();
      check_status("nominal_started", 1'b0, 1'b0, 1'b1, 1'b1);
      send_frame(11, 0, -1);
      @(negedge clk);
      check_nominal_writes("nominal");
      check_status("nominal_done", 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_bad_csum();
      load_nominal_frame();
      frame[10] = 8'hF8;
      clear_log();
      pulse_start();
      check_status("badcsum_restart", 1'b0, 1'b0, 1'b1, 1'b1);
      send_frame(11, 0, -1);
      @(negedge clk);
      check_nominal_writes("badcsum");
      check_status("badcsum_error", 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_oversize();
      frame[0] = 8'h01; frame[1] = 8'h04;
      clear_log();
      pulse_start();
      send_frame(2, 0, -1);
      check_status("oversize_error", 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (6) @(negedge clk);
      tests++;
      if (wr_addr_q.size() != 0) begin
         fails++;
         $display("FAIL oversize_writes: writes=%0d required 0", wr_addr_q.size());
      end
      check_status("oversize_hold", 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_empty();
      frame[0] = 8'h00; frame[1] = 8'h00; frame[2] = 8'h00;
      clear_log();
      pulse_start();
      send_frame(3, 0, -1);
      @(negedge clk);
      tests++;
      if (wr_addr_q.size() != 0) begin
         fails++;
         $display("FAIL empty_writes: writes=%0d required 0", wr_addr_q.size());
      end
      check_status("empty_done", 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_gaps();
      load_nominal_frame();
      clear_log();
      pulse_start();
      send_frame(11, 3, 5);
      @(negedge clk);
      check_nominal_writes("gaps");
      check_status("gaps_done", 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_load();
      load_nominal_frame();
      pulse_start();
      send_frame(6, 0, -1);
      rst = 1'b1;
      #1;
      check_status("midreset_status", 1'b0, 1'b0, 1'b1, 1'b0);
      tests++;
      if ({pm_wr_addr, pm_wr_data} !== {12'h000, 32'h0}) begin
         fails++;
         $display("FAIL midreset_port: addr=%h data=%h required 000 00000000", pm_wr_addr, pm_wr_data);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_status("midreset_idle", 1'b0, 1'b0, 1'b1, 1'b0);
      clear_log();
      pulse_start();
      send_frame(11, 0, -1);
      @(negedge clk);
      check_nominal_writes("midreset_reload");
      check_status("midreset_done", 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      s_data  = 8'h00;
      s_valid = 1'b0;
      @(negedge clk);
      test_reset();
      test_nominal();
      test_bad_csum();
      test_oversize();
      test_empty();
      test_gaps();
      test_reset_mid_load();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
